// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types for the PLL lock sequencer.
//   state_e : sequencer state encoding, also exported on state_dbg.
//   tmr_w() : timer width that covers the longest of the three timed phases.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // The timer only ever counts 0..limit-1, so $clog2(limit) bits suffice.
  function automatic int tmr_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: board-side signal bundle of the PLL lock sequencer.
//   extlock   : PLL lock, asynchronous to clk
//   restart   : one-cycle soft restart request (clk domain)
//   pll_reset : active-high PLL reset
//   sys_rst_n : active-low downstream reset
//   ready/fail: RUN / FAIL indicators
//   retry_cnt : timeouts in the current sequence
//   loss_cnt  : saturating count of lock losses seen in RUN
//   state_dbg : current state encoding
// master = the sequencer, slave = the board / PLL side.
interface pll_lock_sequencer_if #(
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
);
  localparam int RW = $clog2(MAX_RETRY + 1);

  logic             extlock;
  logic             restart;
  logic             pll_reset;
  logic             sys_rst_n;
  logic             ready;
  logic             fail;
  logic [RW-1:0]    retry_cnt;
  logic [CNT_W-1:0] loss_cnt;
  logic [2:0]       state_dbg;

  modport master (
    input  extlock, restart,
    output pll_reset, sys_rst_n, ready, fail, retry_cnt, loss_cnt, state_dbg
  );

  modport slave (
    output extlock, restart,
    input  pll_reset, sys_rst_n, ready, fail, retry_cnt, loss_cnt, state_dbg
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for quasi-static signals, async active-low reset.
//   clk, rst_n : destination clock / reset
//   d_i        : asynchronous input
//   q_o        : synchronized output, two clk edges after d_i settles
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up the board PLL and gates the downstream reset.
//   clk   : free-running reference clock (PLL refclk net)
//   rst_n : async active-low reset
//   bus   : master side of pll_lock_sequencer_if (extlock/restart in,
//           pll_reset/sys_rst_n/ready/fail/retry_cnt/loss_cnt/state_dbg out)
// Sequence: pulse pll_reset, wait for lock with timeout, require a stable lock
// window, then release sys_rst_n. Timeouts retry up to MAX_RETRY times before
// latching FAIL; lock loss in RUN restarts the whole sequence.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_lock_sequencer_if.master  bus
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = tmr_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRY);

  logic lock_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.extlock),
    .q_o   (lock_s)
  );

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_PLL;
      tmr_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next state, timer and counters.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (bus.restart) begin
      state_d = ST_RST_PLL;
      tmr_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (tmr_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so it wins on the timeout cycle.
          if (lock_s) begin
            state_d = ST_STABLE;
            tmr_d   = '0;
          end else if (tmr_q == TO_LAST) begin
            tmr_d = '0;
            if (retry_q == RETRY_MX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = ST_RST_PLL;
            end
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_STABLE: begin
          // A drop here is a failed qualification, not a loss.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            tmr_d   = '0;
          end else if (tmr_q == STB_LAST) begin
            state_d = ST_RUN;
            tmr_d   = '0;
            retry_d = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            if (loss_q != '1) loss_d = loss_q + 1'b1;
            state_d = ST_RST_PLL;
            tmr_d   = '0;
          end
        end
        ST_FAIL: ;
        default: begin
          state_d = ST_RST_PLL;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they flip on the entry edge.
  always_comb begin
    pll_reset_d = (state_d == ST_RST_PLL) || (state_d == ST_FAIL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int CNT_W         = 8;
  localparam int LOSS_SAT      = (1 << CNT_W) - 1;

  // Phase numbers follow the published state_dbg encoding.
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FAIL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pll_lock_sequencer_if #(.MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) bus ();

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: phase, time spent in phase, retries, losses, and the
  // last two sampled extlock values (the FSM reacts to the older one).
  typedef struct {
    int ph;
    int t;
    int retry;
    int loss;
    bit e1;
    bit e2;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t c, input bit el, input bit rs);
    mdl_t n;
    bit   ls;
    n    = c;
    ls   = c.e2;
    n.e2 = c.e1;
    n.e1 = el;
    if (rs) begin
      n.ph = P_RST; n.t = 0; n.retry = 0;
    end else if (c.ph == P_RST) begin
      if (c.t == RST_CYCLES - 1) begin n.ph = P_WAIT; n.t = 0; end
      else n.t = c.t + 1;
    end else if (c.ph == P_WAIT) begin
      if (ls) begin n.ph = P_STB; n.t = 0; end
      else if (c.t == LOCK_TIMEOUT - 1) begin
        n.t = 0;
        if (c.retry == MAX_RETRY) n.ph = P_FAIL;
        else begin n.retry = c.retry + 1; n.ph = P_RST; end
      end else n.t = c.t + 1;
    end else if (c.ph == P_STB) begin
      if (!ls) begin n.ph = P_WAIT; n.t = 0; end
      else if (c.t == STABLE_CYCLES - 1) begin n.ph = P_RUN; n.t = 0; n.retry = 0; end
      else n.t = c.t + 1;
    end else if (c.ph == P_RUN) begin
      if (!ls) begin
        n.loss = (c.loss < LOSS_SAT) ? c.loss + 1 : LOSS_SAT;
        n.ph = P_RST; n.t = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= step(m, bus.extlock, bus.restart);
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pll_reset", int'(bus.pll_reset), int'(m.ph == P_RST || m.ph == P_FAIL));
      chk("sys_rst_n", int'(bus.sys_rst_n), int'(m.ph == P_RUN));
      chk("ready",     int'(bus.ready),     int'(m.ph == P_RUN));
      chk("fail",      int'(bus.fail),      int'(m.ph == P_FAIL));
      chk("retry_cnt", int'(bus.retry_cnt), m.retry);
      chk("loss_cnt",  int'(bus.loss_cnt),  m.loss);
      chk("state_dbg", int'(bus.state_dbg), m.ph);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Assert reset between edges, release on a falling edge.
  task automatic do_reset(input bit el);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.extlock = el;
    bus.restart = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 200 && bus.ready !== 1'b1; i++) tick(1);
    chk(name, int'(bus.ready), 1);
  endtask

  task automatic pulse_restart;
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int hold;
    bus.extlock = 1'b0;
    bus.restart = 1'b0;

    // Nominal lock: extlock raised after edge 10, first sampled at edge 11.
    do_reset(1'b0);
    chk("rst_pll_reset", int'(bus.pll_reset), 1);
    chk("rst_sys_rst_n", int'(bus.sys_rst_n), 0);
    chk("rst_state",     int'(bus.state_dbg), 0);
    tick(3);  chk("nom_pll_hi_e3", int'(bus.pll_reset), 1);
    tick(1);  chk("nom_pll_lo_e4", int'(bus.pll_reset), 0);
    tick(6);  bus.extlock = 1'b1;
    tick(10); chk("nom_ready_e20", int'(bus.ready), 0);
    tick(1);  chk("nom_ready_e21", int'(bus.ready), 1);
    chk("nom_sys_rst_n", int'(bus.sys_rst_n), 1);
    chk("nom_retry",     int'(bus.retry_cnt), 0);

    // Loss in RUN: low for two samples, seen by the FSM two edges later.
    bus.extlock = 1'b0;
    tick(2); chk("loss_ready_hold", int'(bus.ready), 1);
    bus.extlock = 1'b1;
    tick(1); chk("loss_ready_drop", int'(bus.ready), 0);
    chk("loss_sys_rst_n", int'(bus.sys_rst_n), 0);
    chk("loss_cnt_1",     int'(bus.loss_cnt), 1);
    tick(3); chk("loss_pll_hi", int'(bus.pll_reset), 1);
    tick(1); chk("loss_pll_lo", int'(bus.pll_reset), 0);
    wait_ready("loss_relock");

    // Repeated losses until the counter saturates.
    for (int k = 0; k < 260; k++) begin
      bus.extlock = 1'b0;
      tick(1 + $urandom_range(0, 2));
      bus.extlock = 1'b1;
      tick(2);
      wait_ready("sat_relock");
    end
    chk("loss_sat", int'(bus.loss_cnt), LOSS_SAT);

    // Restart mid-RUN.
    pulse_restart();
    chk("rs_run_state", int'(bus.state_dbg), 0);
    chk("rs_run_ready", int'(bus.ready), 0);
    chk("rs_run_loss",  int'(bus.loss_cnt), LOSS_SAT);

    // Restart mid-STABLE (RST 4 edges, then WAIT->STABLE on the next edge).
    tick(6); chk("rs_stb_in_stable", int'(bus.state_dbg), 2);
    pulse_restart();
    chk("rs_stb_state", int'(bus.state_dbg), 0);
    chk("rs_stb_retry", int'(bus.retry_cnt), 0);
    chk("rs_stb_loss",  int'(bus.loss_cnt), LOSS_SAT);

    // Glitch during the stable window.
    do_reset(1'b1);
    tick(7);  chk("gl_in_stable", int'(bus.state_dbg), 2);
    bus.extlock = 1'b0;
    tick(3);  chk("gl_back_wait", int'(bus.state_dbg), 1);
    bus.extlock = 1'b1;
    tick(10); chk("gl_ready_e20", int'(bus.ready), 0);
    tick(1);  chk("gl_ready_e21", int'(bus.ready), 1);
    chk("gl_loss", int'(bus.loss_cnt), 0);

    // One loss, then async reset between edges while in RUN.
    bus.extlock = 1'b0;
    tick(2);
    bus.extlock = 1'b1;
    tick(2);
    wait_ready("ar_relock");
    chk("ar_loss_pre", int'(bus.loss_cnt), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sys_rst_n", int'(bus.sys_rst_n), 0);
    chk("ar_pll_reset", int'(bus.pll_reset), 1);
    chk("ar_ready",     int'(bus.ready), 0);
    chk("ar_loss",      int'(bus.loss_cnt), 0);
    chk("ar_retry",     int'(bus.retry_cnt), 0);
    bus.extlock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Never lock: three 24-cycle attempts, then FAIL.
    tick(24); chk("nl_retry_1", int'(bus.retry_cnt), 1);
    tick(24); chk("nl_retry_2", int'(bus.retry_cnt), 2);
    tick(23); chk("nl_fail_e71", int'(bus.fail), 0);
    tick(1);  chk("nl_fail_e72", int'(bus.fail), 1);
    chk("nl_pll_reset", int'(bus.pll_reset), 1);
    tick(5);  chk("nl_fail_hold", int'(bus.fail), 1);
    pulse_restart();
    chk("nl_rs_state", int'(bus.state_dbg), 0);
    chk("nl_rs_retry", int'(bus.retry_cnt), 0);
    chk("nl_rs_fail",  int'(bus.fail), 0);

    // Random extlock activity with occasional restarts.
    do_reset(1'b0);
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        bus.extlock = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 30);
      end
      hold--;
      bus.restart = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    bus.restart = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controller that sequences the board clock PLL (50 MHz reference in; SDRAM and system clocks out).
- Runs on the free-running reference clock. Pulses the PLL reset, waits for extlock with a timeout, and qualifies lock for a stable window.
- Only after qualification does it release the downstream reset (SDRAM controller, test logic). Retries a bounded number of times, then latches a fault.
- On lock loss it re-asserts the downstream reset and restarts the PLL.

Parameters:
- RST_CYCLES, 16: number of clk cycles pll_reset is held high per attempt (>=2).
- LOCK_TIMEOUT, 50000: cycles to wait for extlock per attempt (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- MAX_RETRY, 3: extra attempts after the first timeout before entering FAIL.
- CNT_W, 8: width of the saturating lock-loss counter.

Ports:
- clk, in, 1: reference clock (same net as the PLL refclk).
- rst_n, in, 1: async active-low reset.
- extlock, in, 1: PLL lock; asynchronous to clk.
- restart, in, 1: single-cycle soft restart request, synchronous to clk.
- pll_reset, out, 1: active-high reset to the PLL.
- sys_rst_n, out, 1: active-low reset to the downstream logic.
- ready, out, 1: high while in RUN.
- fail, out, 1: high while in FAIL.
- retry_cnt, out, $clog2(MAX_RETRY+1): timeouts in the current sequence.
- loss_cnt, out, CNT_W: lock losses seen while in RUN; saturating.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0:
  - state=RST_PLL, pll_reset=1, sys_rst_n=0, ready=0, fail=0.
  - retry_cnt=0, loss_cnt=0, timer=0, extlock sync flops=0.
- Synchronization: extlock passes through 2 flops to produce lock_s (2-edge latency). No other logic uses raw extlock.
- All outputs are registered. Each output is valid the same edge the state is entered.
- RST_PLL:
  - pll_reset=1, sys_rst_n=0; timer counts 0..RST_CYCLES-1.
  - At RST_CYCLES-1: go to WAIT_LOCK, timer=0.
- WAIT_LOCK:
  - pll_reset=0; timer increments each cycle.
  - If lock_s=1: go to STABLE, timer=0.
  - Else at timer==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - otherwise retry_cnt+1 and go to RST_PLL.
  - If lock_s rises on the timeout cycle, lock wins.
- STABLE:
  - timer increments while lock_s=1.
  - If lock_s=0: go to WAIT_LOCK, timer=0; retry_cnt unchanged; this drop does not count toward loss_cnt.
  - At timer==STABLE_CYCLES-1 with lock_s=1: go to RUN.
- RUN:
  - sys_rst_n=1, ready=1, retry_cnt cleared to 0 on entry.
  - If lock_s=0: loss_cnt+1 (saturates at all-ones) and go to RST_PLL. sys_rst_n=0 and ready=0 from that same edge.
- FAIL:
  - pll_reset=1, sys_rst_n=0, fail=1.
  - Stays in FAIL until restart is seen.
- restart=1 in any state:
  - Highest priority: go to RST_PLL, timer=0, retry_cnt=0.
  - loss_cnt is preserved; only rst_n clears it.
- Nominal latency: if edge E0 first samples extlock=1 in WAIT_LOCK, ready is high after edge E0+2+STABLE_CYCLES.
- Counter widths are sized by $clog2 of each limit; the timer is sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). No wrap-around is reachable except loss_cnt, which saturates.
- rst_n asserted mid-RUN: sys_rst_n drops immediately (async); the full sequence reruns after release.

Decomposition:
- Package pll_seq_pkg:
  - state encoding: RST_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4;
  - the timer width function.
- Sub-module sync_2ff (parameterized width, async active-low reset) for extlock. It is reusable by the SDRAM blocks.

Test Plan (params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2):
- Nominal lock: release rst_n; raise extlock at cycle 10 and hold -> pll_reset high for cycles 0-3; ready and sys_rst_n rise exactly 10 edges after extlock is first sampled; retry_cnt=0.
- Never lock: extlock=0 forever -> three 24-cycle attempts with pll_reset pulsed three times; retry_cnt steps 1,2; fail=1 and pll_reset=1 after cycle 72; then restart pulse -> state RST_PLL, retry_cnt=0, fail=0.
- Glitch in STABLE: drop extlock for 3 cycles during the stable window -> returns to WAIT_LOCK; ready stays 0; ready rises 10 edges after lock returns; loss_cnt=0.
- Loss in RUN: drop extlock while ready=1 -> after 2 sync edges, sys_rst_n=0, ready=0, loss_cnt=1, pll_reset pulses 4 cycles; relock yields ready again. Repeat 255+ times with CNT_W=8 -> loss_cnt saturates at 255.
- Restart mid-STABLE and mid-RUN: pulse restart -> next edge state RST_PLL, ready=0, retry_cnt=0, loss_cnt unchanged.
- Async reset: assert rst_n=0 between clk edges in RUN -> sys_rst_n=0 and pll_reset=1 before the next edge; all counters 0.
